// File: rtl/game_pkg.sv
// Shared stage encodings, spawner state type and kill-count helpers for the game slice.
package game_pkg;

  localparam logic [1:0] STAGE_INIT   = 2'b00;
  localparam logic [1:0] STAGE_NORMAL = 2'b01;
  localparam logic [1:0] STAGE_BOSS   = 2'b10;
  localparam logic [1:0] STAGE_CLEAR  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAVE = 2'b01,
    S_BOSS = 2'b10,
    S_DONE = 2'b11
  } spawner_state_e;

  localparam int unsigned KILL_SAT = 255;

  // 9-bit sum so a carry out of the 8-bit count clamps instead of wrapping.
  function automatic logic [7:0] sat_add_kill(input logic [7:0] cnt, input logic [7:0] inc);
    logic [8:0] sum;
    sum = {1'b0, cnt} + {1'b0, inc};
    return (sum > 9'(KILL_SAT)) ? 8'(KILL_SAT) : sum[7:0];
  endfunction

endpackage

// File: rtl/hit_popcount.sv
// Combinational population count of a newly-killed vector.
module hit_popcount #(
  parameter int unsigned WIDTH = 17,
  localparam int unsigned CW   = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/enemy_spawner.sv
// Enemy alive-state owner: spawns the wave on INIT, the spider on BOSS, clears enemies on hits.
// Optional spider post-hit invulnerability timer is built when SPIDER_INVULN_EN is defined.
module enemy_spawner
  import game_pkg::*;
#(
  parameter int unsigned FLY_COUNT      = 4,
  parameter int unsigned MOSQUITO_COUNT = 12,
  parameter int unsigned SPIDER_HP      = 8,
  parameter int unsigned INVULN_TICKS   = 12_500_000
) (
  input  logic                      clk25,
  input  logic                      rst,
  input  logic [1:0]                stage_state,
  input  logic [FLY_COUNT-1:0]      fly_hit,
  input  logic [MOSQUITO_COUNT-1:0] mosquito_hit,
  input  logic                      spider_hit,
  output logic [FLY_COUNT-1:0]      fly_alive,
  output logic [MOSQUITO_COUNT-1:0] mosquito_alive,
  output logic                      spider_alive,
  output logic [7:0]                spider_hp,
  output logic [7:0]                kill_count,
  output logic                      enemy_killed
);

  localparam int unsigned NUM_TARGETS = FLY_COUNT + MOSQUITO_COUNT + 1;
  localparam int unsigned POP_W       = $clog2(NUM_TARGETS + 1);

  if (SPIDER_HP < 1 || SPIDER_HP > 255 || INVULN_TICKS >= 32'd16777216) begin : g_param_check
    $error("enemy_spawner: SPIDER_HP must be 1..255 and INVULN_TICKS must fit in 24 bits");
  end

  spawner_state_e            state_q, state_d;
  logic [FLY_COUNT-1:0]      fly_q, fly_d, fly_kill;
  logic [MOSQUITO_COUNT-1:0] mosq_q, mosq_d, mosq_kill;
  logic                      spider_q, spider_d;
  logic [7:0]                hp_q, hp_d;
  logic [7:0]                kill_q, kill_d;
  logic                      killed_q, killed_d;

  logic                      init;
  logic                      spider_accept;
  logic                      boss_hit;
  logic                      spider_death;
  logic [NUM_TARGETS-1:0]    newly_killed;
  logic [POP_W-1:0]          kill_pop;

  assign init         = (stage_state == STAGE_INIT);
  assign boss_hit     = (state_q == S_BOSS) && spider_accept;
  assign spider_death = boss_hit && (hp_q == 8'd1);

`ifdef SPIDER_INVULN_EN
  logic [23:0] timer_q, timer_d;

  assign spider_accept = spider_hit && (timer_q == '0);

  always_comb begin
    timer_d = (timer_q != '0) ? timer_q - 24'd1 : '0;
    if (boss_hit) begin
      timer_d = 24'(INVULN_TICKS);
    end
    if (init || spider_death) begin
      timer_d = '0;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_d;
    end
  end
`else
  assign spider_accept = spider_hit;
`endif

  always_comb begin
    state_d   = state_q;
    fly_d     = fly_q;
    mosq_d    = mosq_q;
    spider_d  = spider_q;
    hp_d      = hp_q;
    fly_kill  = '0;
    mosq_kill = '0;

    unique case (state_q)
      S_WAVE: begin
        // A kill is a live bit being hit; hits on dead bits fall out of the AND.
        fly_kill  = fly_q & fly_hit;
        mosq_kill = mosq_q & mosquito_hit;
        fly_d     = fly_q & ~fly_hit;
        mosq_d    = mosq_q & ~mosquito_hit;
        if (stage_state == STAGE_BOSS) begin
          spider_d = 1'b1;
          hp_d     = 8'(SPIDER_HP);
          state_d  = S_BOSS;
        end
      end
      S_BOSS: begin
        if (boss_hit) begin
          if (spider_death) begin
            hp_d     = '0;
            spider_d = 1'b0;
            state_d  = S_DONE;
          end else begin
            hp_d = hp_q - 8'd1;
          end
        end
      end
      S_IDLE, S_DONE: ;
    endcase

    if (init) begin
      fly_d     = '1;
      mosq_d    = '1;
      spider_d  = 1'b0;
      hp_d      = '0;
      state_d   = S_WAVE;
      fly_kill  = '0;
      mosq_kill = '0;
    end
  end

  assign newly_killed = {spider_death && !init, mosq_kill, fly_kill};

  hit_popcount #(
    .WIDTH(NUM_TARGETS)
  ) u_hit_popcount (
    .bits (newly_killed),
    .count(kill_pop)
  );

  always_comb begin
    kill_d   = sat_add_kill(kill_q, 8'(kill_pop));
    killed_d = (kill_pop != '0);
    if (init) begin
      kill_d   = '0;
      killed_d = 1'b0;
    end
  end

  always_ff @(posedge clk25 or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      fly_q    <= '0;
      mosq_q   <= '0;
      spider_q <= 1'b0;
      hp_q     <= '0;
      kill_q   <= '0;
      killed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      fly_q    <= fly_d;
      mosq_q   <= mosq_d;
      spider_q <= spider_d;
      hp_q     <= hp_d;
      kill_q   <= kill_d;
      killed_q <= killed_d;
    end
  end

  assign fly_alive      = fly_q;
  assign mosquito_alive = mosq_q;
  assign spider_alive   = spider_q;
  assign spider_hp      = hp_q;
  assign kill_count     = kill_q;
  assign enemy_killed   = killed_q;

endmodule

// File: tb/tb_enemy_spawner.sv
// Self-checking bench for enemy_spawner: per-cycle model comparison plus pinned literal values.
// Build with SPIDER_INVULN_EN defined to exercise the spider invulnerability timer.
module tb_enemy_spawner;

  localparam int FLY    = 4;
  localparam int MOSQ   = 12;
  localparam int HP0    = 8;
  localparam int TICKS  = 10;

  localparam logic [1:0] ST_INIT   = 2'b00;
  localparam logic [1:0] ST_NORMAL = 2'b01;
  localparam logic [1:0] ST_BOSS   = 2'b10;
  localparam logic [1:0] ST_CLEAR  = 2'b11;

  logic            clk25;
  logic            rst;
  logic [1:0]      stage_state;
  logic [FLY-1:0]  fly_hit;
  logic [MOSQ-1:0] mosquito_hit;
  logic            spider_hit;
  logic [FLY-1:0]  fly_alive;
  logic [MOSQ-1:0] mosquito_alive;
  logic            spider_alive;
  logic [7:0]      spider_hp;
  logic [7:0]      kill_count;
  logic            enemy_killed;

  enemy_spawner #(
    .FLY_COUNT     (FLY),
    .MOSQUITO_COUNT(MOSQ),
    .SPIDER_HP     (HP0),
    .INVULN_TICKS  (TICKS)
  ) dut (
    .clk25         (clk25),
    .rst           (rst),
    .stage_state   (stage_state),
    .fly_hit       (fly_hit),
    .mosquito_hit  (mosquito_hit),
    .spider_hit    (spider_hit),
    .fly_alive     (fly_alive),
    .mosquito_alive(mosquito_alive),
    .spider_alive  (spider_alive),
    .spider_hp     (spider_hp),
    .kill_count    (kill_count),
    .enemy_killed  (enemy_killed)
  );

  initial clk25 = 1'b0;
  always #5 clk25 = ~clk25;

  // Behavioural model: round phase plus plain counters.
  localparam int PH_IDLE = 0, PH_WAVE = 1, PH_BOSS = 2, PH_DONE = 3;
  int              m_phase;
  logic [FLY-1:0]  m_fly;
  logic [MOSQ-1:0] m_mosq;
  int              m_spider;
  int              m_hp;
  int              m_kill;
  int              m_killed;
  int              m_timer;
  int              m_k;
  int              m_accept;

  always @(posedge clk25 or posedge rst) begin
    if (rst) begin
      m_phase = PH_IDLE; m_fly = '0; m_mosq = '0; m_spider = 0; m_hp = 0;
      m_kill = 0; m_killed = 0; m_timer = 0;
    end else if (stage_state == ST_INIT) begin
      m_phase = PH_WAVE; m_fly = '1; m_mosq = '1; m_spider = 0; m_hp = 0;
      m_kill = 0; m_killed = 0; m_timer = 0;
    end else begin
      m_k = 0;
      m_accept = 0;
      if (m_phase == PH_WAVE) begin
        for (int i = 0; i < FLY; i++)
          if (m_fly[i] && fly_hit[i]) begin m_fly[i] = 1'b0; m_k++; end
        for (int i = 0; i < MOSQ; i++)
          if (m_mosq[i] && mosquito_hit[i]) begin m_mosq[i] = 1'b0; m_k++; end
        if (stage_state == ST_BOSS) begin
          m_spider = 1; m_hp = HP0; m_phase = PH_BOSS;
        end
      end else if (m_phase == PH_BOSS) begin
`ifdef SPIDER_INVULN_EN
        m_accept = (spider_hit && m_timer == 0) ? 1 : 0;
`else
        m_accept = spider_hit ? 1 : 0;
`endif
        if (m_accept != 0) begin
          m_hp = m_hp - 1;
          if (m_hp == 0) begin m_spider = 0; m_k++; m_phase = PH_DONE; end
        end
      end
`ifdef SPIDER_INVULN_EN
      if (m_accept != 0) m_timer = (m_phase == PH_DONE) ? 0 : TICKS;
      else if (m_timer > 0) m_timer = m_timer - 1;
`endif
      m_kill   = (m_kill + m_k > 255) ? 255 : m_kill + m_k;
      m_killed = (m_k > 0) ? 1 : 0;
    end
  end

  // Literal expectations: set by stimulus just after a posedge, checked at the next negedge.
  logic        lit_en  [6];
  logic [31:0] lit_exp [6];
  string       names   [6] = '{"fly_alive", "mosquito_alive", "spider_alive", "spider_hp",
                               "kill_count", "enemy_killed"};
  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      0:       return 32'(fly_alive);
      1:       return 32'(mosquito_alive);
      2:       return 32'(spider_alive);
      3:       return 32'(spider_hp);
      4:       return 32'(kill_count);
      default: return 32'(enemy_killed);
    endcase
  endfunction

  function automatic logic [31:0] model_val(input int sel);
    case (sel)
      0:       return 32'(m_fly);
      1:       return 32'(m_mosq);
      2:       return 32'(m_spider);
      3:       return 32'(m_hp);
      4:       return 32'(m_kill);
      default: return 32'(m_killed);
    endcase
  endfunction

  always @(negedge clk25) begin
    for (int s = 0; s < 6; s++) begin
      n_cmp++;
      if (dut_val(s) !== model_val(s)) begin
        n_bad++;
        $display("FAIL model %s at %0t: dut=%0h model=%0h", names[s], $time, dut_val(s),
                 model_val(s));
      end
      if (lit_en[s]) begin
        n_cmp++;
        if (dut_val(s) !== lit_exp[s]) begin
          n_bad++;
          $display("FAIL pinned %s at %0t: dut=%0h expected=%0h", names[s], $time, dut_val(s),
                   lit_exp[s]);
        end
        n_cmp++;
        if (model_val(s) !== lit_exp[s]) begin
          n_bad++;
          $display("FAIL pinned-model %s at %0t: model=%0h expected=%0h", names[s], $time,
                   model_val(s), lit_exp[s]);
        end
      end
    end
  end

  task automatic clear_pins();
    for (int s = 0; s < 6; s++) lit_en[s] = 1'b0;
  endtask

  task automatic pin(input int sel, input logic [31:0] v);
    lit_en[sel]  = 1'b1;
    lit_exp[sel] = v;
  endtask

  // Inputs applied here are consumed at the next posedge.
  task automatic drive(input logic [1:0] st, input logic [FLY-1:0] fh, input logic [MOSQ-1:0] mh,
                       input logic sh);
    @(posedge clk25);
    #1;
    clear_pins();
    stage_state  = st;
    fly_hit      = fh;
    mosquito_hit = mh;
    spider_hit   = sh;
  endtask

  initial begin
    clear_pins();
    rst = 1'b1; stage_state = ST_NORMAL; fly_hit = '0; mosquito_hit = '0; spider_hit = 1'b0;
    for (int s = 0; s < 6; s++) pin(s, 32'h0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    rst = 1'b0;

    // Idle ignores hits and BOSS until INIT.
    drive(ST_BOSS, 4'hF, 12'hFFF, 1'b1);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'h0); pin(3, 32'h0); pin(4, 32'h0);

    // Wave spawn.
    drive(ST_INIT, '0, '0, 1'b0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'hF); pin(1, 32'hFFF); pin(4, 32'h0); pin(2, 32'h0);

    // Wave hits, then the same hits again on dead bits.
    drive(ST_NORMAL, 4'b0101, 12'h003, 1'b0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'hA); pin(1, 32'hFFC); pin(4, 32'd4); pin(5, 32'h1);
    drive(ST_NORMAL, 4'b0101, 12'h003, 1'b0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'hA); pin(1, 32'hFFC); pin(4, 32'd4); pin(5, 32'h0);

    // Clear the rest of the wave.
    drive(ST_NORMAL, 4'b1010, 12'hFFC, 1'b0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'h0); pin(1, 32'h0); pin(4, 32'd16); pin(5, 32'h1);

    // Boss spawn; a hit in the first BOSS cycle is ignored.
    drive(ST_BOSS, '0, '0, 1'b1);
    drive(ST_BOSS, '0, '0, 1'b0);
    pin(2, 32'h1); pin(3, 32'd8);

`ifdef SPIDER_INVULN_EN
    drive(ST_BOSS, '0, '0, 1'b1);
    for (int c = 1; c <= 12; c++) begin
      drive(ST_BOSS, '0, '0, (c == 5 || c == 11));
      if (c == 1 || c == 6) pin(3, 32'd7);
      if (c == 12) begin pin(3, 32'd6); pin(2, 32'h1); end
    end
`else
    drive(ST_BOSS, '0, '0, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      drive(ST_BOSS, 4'hF, 12'hFFF, (i < 8));
      pin(3, 32'(8 - i));
    end
    pin(2, 32'h0); pin(4, 32'd17); pin(5, 32'h1);
    drive(ST_CLEAR, '0, '0, 1'b1);
    drive(ST_CLEAR, '0, '0, 1'b0);
    pin(3, 32'h0); pin(4, 32'd17); pin(5, 32'h0);
`endif

    // INIT wins over same-cycle hits.
    drive(ST_INIT, 4'hF, 12'hFFF, 1'b1);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'hF); pin(1, 32'hFFF); pin(2, 32'h0); pin(3, 32'h0); pin(4, 32'h0); pin(5, 32'h0);

    // Back into BOSS, take one spider hit, then reset mid-cycle.
    drive(ST_NORMAL, 4'hF, 12'hFFF, 1'b0);
    drive(ST_BOSS, '0, '0, 1'b0);
    drive(ST_BOSS, '0, '0, 1'b1);
    drive(ST_BOSS, '0, '0, 1'b0);
    pin(2, 32'h1); pin(3, 32'd7); pin(4, 32'd16);
    @(posedge clk25);
    #3;
    clear_pins();
    rst = 1'b1;
    for (int s = 0; s < 6; s++) pin(s, 32'h0);
    drive(ST_BOSS, '0, '0, 1'b0);
    rst = 1'b0;

    // Stays idle after reset until INIT.
    drive(ST_BOSS, 4'hF, 12'hFFF, 1'b1);
    drive(ST_NORMAL, 4'hF, 12'hFFF, 1'b1);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'h0); pin(1, 32'h0); pin(2, 32'h0); pin(3, 32'h0); pin(4, 32'h0);
    drive(ST_INIT, '0, '0, 1'b0);
    drive(ST_NORMAL, '0, '0, 1'b0);
    pin(0, 32'hF); pin(1, 32'hFFF);
    drive(ST_NORMAL, '0, '0, 1'b0);
    @(negedge clk25);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
